// File: rtl/counter_gen.sv
// counter_gen: parametrised up/down counter with enable, clear, load,
// wrap/saturate boundary mode, clock prescaler, registered wrap pulse and
// sticky overflow flag.
module counter_gen #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf
);

    localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_C   = MAX_VAL[WIDTH-1:0];
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             boundary;

    // Next-state: clr > load > prescaled counting step; boundary drives wrap/ovf.
    always_comb begin
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        boundary = 1'b0;
        if (clr) begin
            cnt_d = '0;
            pre_d = '0;
        end else if (load) begin
            cnt_d = (load_val > MAX_C) ? MAX_C : load_val;
            pre_d = '0;
        end else if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                // Compares use == against the bounds, so MAX_C = all-ones never overflows.
                if (up) begin
                    if (cnt_q == MAX_C) begin
                        boundary = 1'b1;
                        cnt_d    = sat_mode ? MAX_C : '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        boundary = 1'b1;
                        cnt_d    = sat_mode ? '0 : MAX_C;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
        wrap_d = boundary;
        ovf_d  = boundary | (ovf_q & ~ovf_clr);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign count = cnt_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_gen.sv
// tb_counter_gen: two counter_gen instances (defaults; WIDTH=5/MAX_VAL=17/
// PRESCALE=3) driven by shared directed and random stimulus and compared
// against an integer reference model every cycle.
module tb_counter_gen;

    logic       clk = 1'b0;
    logic       rst, en, up, sat_mode, clr, load, ovf_clr;
    logic [4:0] load_val;
    logic [3:0] cnt_a;
    logic       wrap_a, ovf_a;
    logic [4:0] cnt_b;
    logic       wrap_b, ovf_b;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int m_cnt [2];
    int m_pre [2];
    bit m_wrap[2];
    bit m_ovf [2];
    int MAXV  [2] = '{15, 17};
    int PSC   [2] = '{1, 3};
    int LVMOD [2] = '{16, 32};

    always #5 clk = ~clk;

    counter_gen #(.WIDTH(4)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val[3:0]), .ovf_clr(ovf_clr),
        .count(cnt_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    counter_gen #(.WIDTH(5), .MAX_VAL(17), .PRESCALE(3)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(cnt_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model for instance i.
    function automatic void model_edge(input int i);
        int lv;
        bit ev;
        lv = int'(load_val) % LVMOD[i];
        ev = 1'b0;
        if (rst) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
            return;
        end
        if (clr) begin
            m_cnt[i] = 0; m_pre[i] = 0;
        end else if (load) begin
            m_cnt[i] = (lv > MAXV[i]) ? MAXV[i] : lv;
            m_pre[i] = 0;
        end else if (en) begin
            m_pre[i]++;
            if (m_pre[i] == PSC[i]) begin
                m_pre[i] = 0;
                if (up) begin
                    if (m_cnt[i] < MAXV[i]) m_cnt[i]++;
                    else begin ev = 1; m_cnt[i] = sat_mode ? MAXV[i] : 0; end
                end else begin
                    if (m_cnt[i] > 0) m_cnt[i]--;
                    else begin ev = 1; m_cnt[i] = sat_mode ? 0 : MAXV[i]; end
                end
            end
        end
        m_wrap[i] = ev;
        m_ovf[i]  = ev || (m_ovf[i] && !ovf_clr);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("A.count", 32'(cnt_a),  32'(m_cnt[0]));
        check("A.wrap",  32'(wrap_a), 32'(m_wrap[0]));
        check("A.ovf",   32'(ovf_a),  32'(m_ovf[0]));
        check("B.count", 32'(cnt_b),  32'(m_cnt[1]));
        check("B.wrap",  32'(wrap_b), 32'(m_wrap[1]));
        check("B.ovf",   32'(ovf_b),  32'(m_ovf[1]));
    endtask

    task automatic set_in(input logic r, input logic e, input logic u, input logic s,
                          input logic c, input logic l, input logic [4:0] lv, input logic oc);
        rst = r; en = e; up = u; sat_mode = s; clr = c; load = l; load_val = lv; ovf_clr = oc;
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 5'd0, 0);
        m_cnt = '{0, 0}; m_pre = '{0, 0}; m_wrap = '{0, 0}; m_ovf = '{0, 0};

        // Reset for two cycles, then count up across the wrap.
        tick(); tick();
        check("reset.countA", 32'(cnt_a), 32'd0);
        check("reset.countB", 32'(cnt_b), 32'd0);
        set_in(0, 1, 1, 0, 0, 0, 5'd0, 0);
        repeat (20) tick();
        check("wrap.ovfA", 32'(ovf_a), 32'd1);

        // Down from 0 in wrap mode, then clear ovf.
        set_in(0, 1, 0, 0, 1, 0, 5'd0, 0); tick();
        set_in(0, 1, 0, 0, 0, 0, 5'd0, 0);
        repeat (9) tick();
        set_in(0, 1, 0, 0, 0, 0, 5'd0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 5'd0, 1); tick();
        check("ovfclr.A", 32'(ovf_a), 32'd0);
        check("ovfclr.B", 32'(ovf_b), 32'd0);

        // Saturate at top: load 14, step up 4 times, then step down.
        set_in(0, 1, 1, 1, 0, 1, 5'd14, 0); tick();
        check("sat.load14", 32'(cnt_a), 32'd14);
        set_in(0, 1, 1, 1, 0, 0, 5'd14, 0);
        repeat (4) tick();
        check("sat.hold15", 32'(cnt_a), 32'd15);
        check("sat.wrap",   32'(wrap_a), 32'd1);
        set_in(0, 1, 0, 1, 0, 0, 5'd0, 0); tick();
        check("sat.down14", 32'(cnt_a), 32'd14);

        // Prescaler with enable dropped mid-period.
        set_in(0, 1, 1, 0, 1, 0, 5'd0, 0); tick();
        set_in(0, 1, 1, 0, 0, 0, 5'd0, 0); repeat (4) tick();
        set_in(0, 0, 1, 0, 0, 0, 5'd0, 0); repeat (2) tick();
        set_in(0, 1, 1, 0, 0, 0, 5'd0, 0); repeat (5) tick();

        // Priority: clr beats load; load clamps to MAX_VAL.
        set_in(0, 1, 1, 0, 0, 1, 5'd7, 0); tick();
        set_in(0, 1, 1, 0, 1, 1, 5'd5, 0); tick();
        check("prio.clrA", 32'(cnt_a), 32'd0);
        check("prio.clrB", 32'(cnt_b), 32'd0);
        set_in(0, 1, 1, 0, 0, 1, 5'd20, 0); tick();
        check("clamp.B", 32'(cnt_b), 32'd17);

        // ovf_clr coincident with a wrap step: set wins.
        set_in(0, 1, 1, 0, 0, 1, 5'd15, 0); tick();
        set_in(0, 1, 1, 0, 0, 0, 5'd0, 1); tick();
        check("setwins.wrap", 32'(wrap_a), 32'd1);
        check("setwins.ovf",  32'(ovf_a),  32'd1);

        // Reset mid-count with prescaler mid-period, then resume.
        set_in(0, 1, 1, 0, 0, 1, 5'd11, 0); tick();
        set_in(0, 1, 1, 0, 0, 0, 5'd0, 0); tick();
        set_in(1, 1, 1, 0, 0, 0, 5'd0, 0); tick();
        check("rst.countB", 32'(cnt_b), 32'd0);
        set_in(0, 1, 1, 0, 0, 0, 5'd0, 0); repeat (4) tick();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
                   1'($urandom), ($urandom_range(15) == 0), ($urandom_range(15) == 0),
                   5'($urandom), ($urandom_range(7) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
